// File: rtl/axi_lite_req_arbiter_if.sv
// Bundle of requester-side and AXI4-Lite master-side signals for axi_lite_req_arbiter.
// master modport: the arbiter's view (serves requesters, drives the AXI command).
// slave modport: the surrounding environment's view (requesters plus AXI master).
interface axi_lite_req_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned DW = 32;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_write;
  logic [DW*NUM_REQ-1:0] req_addr;
  logic [DW*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [DW-1:0]         rsp_rdata;
  logic                  busy;
  logic                  AXI_Start;
  logic                  AXI_WriteEn;
  logic [DW-1:0]         AXI_Addr;
  logic [DW-1:0]         AXI_WData;
  logic [DW-1:0]         AXI_RData;
  logic                  AXI_Done;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, AXI_RData, AXI_Done,
    output req_ready, rsp_valid, rsp_rdata, busy,
           AXI_Start, AXI_WriteEn, AXI_Addr, AXI_WData
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, AXI_RData, AXI_Done,
    input  req_ready, rsp_valid, rsp_rdata, busy,
           AXI_Start, AXI_WriteEn, AXI_Addr, AXI_WData
  );
endinterface

// File: rtl/axi_lite_req_arbiter.sv
// N-requester arbiter in front of a single AXI4-Lite command master.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins);
// otherwise arbitration is round-robin starting after the last granted requester.
module axi_lite_req_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_lite_req_arbiter_if.master bus
);
  localparam int unsigned DW    = 32;
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic               cmd_write_q, cmd_write_d;
  logic [DW-1:0]      cmd_addr_q, cmd_addr_d;
  logic [DW-1:0]      cmd_wdata_q, cmd_wdata_d;
  logic [DW-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
`ifndef ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
`endif

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  logic [DW-1:0]      addr_arr  [NUM_REQ];
  logic [DW-1:0]      wdata_arr [NUM_REQ];

  // Unpack per-requester address and write data lanes.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = bus.req_addr[DW*g +: DW];
    assign wdata_arr[g] = bus.req_wdata[DW*g +: DW];
  end

  // Pick the arbitration winner among active requesters.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
`ifdef ARB_FIXED_PRIO_EN
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'(k);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`else
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(last_grant_q) + k) % NUM_REQ);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`endif
  end

  // Accept pulse is same-cycle with the IDLE decision; suppressed while in reset.
  assign bus.req_ready = (!rst && state_q == ST_IDLE && win_found)
                         ? (NUM_REQ'(1) << win_idx) : '0;

  // Next-state, command latch and registered-output computation.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
`ifndef ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant_d     = win_idx;
          cmd_write_d = bus.req_write[win_idx];
          cmd_addr_d  = addr_arr[win_idx];
          cmd_wdata_d = wdata_arr[win_idx];
`ifndef ARB_FIXED_PRIO_EN
          last_grant_d = win_idx;
`endif
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.AXI_Done) begin
          rsp_rdata_d = bus.AXI_RData;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    start_d     = (state_d == ST_ISSUE);
    busy_d      = (state_d != ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP) ? (NUM_REQ'(1) << grant_d) : '0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_valid_q <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_grant_q <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_valid_q <= rsp_valid_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
`ifndef ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign bus.AXI_Start   = start_q;
  assign bus.AXI_WriteEn = cmd_write_q;
  assign bus.AXI_Addr    = cmd_addr_q;
  assign bus.AXI_WData   = cmd_wdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Directed self-checking bench for axi_lite_req_arbiter (NUM_REQ = 4).
// Honours ARB_FIXED_PRIO_EN when choosing the expected grant order.
module tb_axi_lite_req_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  axi_lite_req_arbiter_if #(.NUM_REQ(4)) bus ();

  axi_lite_req_arbiter #(.NUM_REQ(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction starting from the next (IDLE) cycle.
  task automatic txn(input string tag, input logic [3:0] vld, input logic hold, input int lat,
                     input logic [31:0] rdata, input logic [3:0] mid_vld, input logic [3:0] exp_rdy,
                     input logic exp_we, input logic [31:0] exp_addr, input logic [31:0] exp_wdata);
    @(negedge clk);
    bus.req_valid = vld;
    #1;
    check_eq({tag, "/ready"}, 32'(bus.req_ready), 32'(exp_rdy));
    check_eq({tag, "/busy_idle"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    if (!hold) bus.req_valid = '0;
    #1;
    check_eq({tag, "/start"}, 32'(bus.AXI_Start), 32'd1);
    check_eq({tag, "/we"}, 32'(bus.AXI_WriteEn), 32'(exp_we));
    check_eq({tag, "/addr"}, bus.AXI_Addr, exp_addr);
    check_eq({tag, "/wdata"}, bus.AXI_WData, exp_wdata);
    check_eq({tag, "/busy_issue"}, 32'(bus.busy), 32'd1);
    check_eq({tag, "/ready_issue"}, 32'(bus.req_ready), 32'd0);
    repeat (lat) begin
      @(negedge clk);
      if (!hold) bus.req_valid = mid_vld;
      #1;
      check_eq({tag, "/start_wait"}, 32'(bus.AXI_Start), 32'd0);
      check_eq({tag, "/busy_wait"}, 32'(bus.busy), 32'd1);
      check_eq({tag, "/ready_wait"}, 32'(bus.req_ready), 32'd0);
      check_eq({tag, "/rspv_wait"}, 32'(bus.rsp_valid), 32'd0);
    end
    bus.AXI_RData = rdata;
    bus.AXI_Done  = 1'b1;
    @(negedge clk);
    bus.AXI_Done = 1'b0;
    #1;
    check_eq({tag, "/rsp_valid"}, 32'(bus.rsp_valid), 32'(exp_rdy));
    check_eq({tag, "/rsp_rdata"}, bus.rsp_rdata, rdata);
    check_eq({tag, "/ready_resp"}, 32'(bus.req_ready), 32'd0);
    check_eq({tag, "/start_resp"}, 32'(bus.AXI_Start), 32'd0);
    check_eq({tag, "/busy_resp"}, 32'(bus.busy), 32'd1);
  endtask

  logic [3:0]  rr_exp [5];
  logic [31:0] addr_of [4];
  logic [31:0] wdata_of [4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    addr_of  = '{32'h0000_0010, 32'h0000_0018, 32'h0000_0020, 32'h0000_0040};
    wdata_of = '{32'h1111_1111, 32'h2222_2222, 32'h1234_5678, 32'h4444_4444};
`ifdef ARB_FIXED_PRIO_EN
    rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    rst           = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_write = 4'b0000;
    bus.req_addr  = {addr_of[3], addr_of[2], addr_of[1], addr_of[0]};
    bus.req_wdata = {wdata_of[3], wdata_of[2], wdata_of[1], wdata_of[0]};
    bus.AXI_RData = 32'hFFFF_FFFF;
    bus.AXI_Done  = 1'b1;

    // Reset values, with live inputs during reset.
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst/ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst/busy", 32'(bus.busy), 32'd0);
    check_eq("rst/start", 32'(bus.AXI_Start), 32'd0);
    check_eq("rst/we", 32'(bus.AXI_WriteEn), 32'd0);
    check_eq("rst/addr", bus.AXI_Addr, 32'd0);
    check_eq("rst/wdata", bus.AXI_WData, 32'd0);
    check_eq("rst/rdata", bus.rsp_rdata, 32'd0);
    bus.req_valid = '0;
    bus.AXI_Done  = 1'b0;
    rst           = 1'b0;

    // Continuous 1111 request: grant order.
    for (int i = 0; i < 5; i++) begin
      int g;
      g = (rr_exp[i] == 4'b0001) ? 0 : (rr_exp[i] == 4'b0010) ? 1 : (rr_exp[i] == 4'b0100) ? 2 : 3;
      txn($sformatf("rr%0d", i), 4'b1111, 1'b1, 1, 32'hA000_0000 + 32'(i), 4'b0000,
          rr_exp[i], 1'b0, addr_of[g], wdata_of[g]);
    end
    bus.req_valid = '0;

    // Read from requester 0.
    txn("read", 4'b0001, 1'b0, 2, 32'hDEAD_BEEF, 4'b0000, 4'b0001, 1'b0,
        32'h0000_0010, wdata_of[0]);
    @(negedge clk);
    #1;
    check_eq("read/idle_rspv", 32'(bus.rsp_valid), 32'd0);
    check_eq("read/idle_busy", 32'(bus.busy), 32'd0);
    check_eq("read/rdata_hold", bus.rsp_rdata, 32'hDEAD_BEEF);
    check_eq("read/addr_hold", bus.AXI_Addr, 32'h0000_0010);

    // Write from requester 2.
    bus.req_write = 4'b0100;
    txn("write", 4'b0100, 1'b0, 3, 32'hCAFE_0001, 4'b0000, 4'b0100, 1'b1,
        32'h0000_0020, 32'h1234_5678);
    bus.req_write = 4'b0000;

    // Long stall with requester 1 arriving during WAIT, Done coinciding.
    txn("stall", 4'b1000, 1'b0, 50, 32'h5555_0001, 4'b0010, 4'b1000, 1'b0,
        addr_of[3], wdata_of[3]);
    txn("after_stall", 4'b0010, 1'b0, 1, 32'h5555_0002, 4'b0000, 4'b0010, 1'b0,
        addr_of[1], wdata_of[1]);

    // Spurious Done while idle.
    @(negedge clk);
    bus.AXI_RData = 32'hBAD0_BAD0;
    bus.AXI_Done  = 1'b1;
    #1;
    check_eq("spur/ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    bus.AXI_Done = 1'b0;
    #1;
    check_eq("spur/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("spur/busy", 32'(bus.busy), 32'd0);
    check_eq("spur/start", 32'(bus.AXI_Start), 32'd0);
    check_eq("spur/rdata", bus.rsp_rdata, 32'h5555_0002);
    @(negedge clk);
    #1;
    check_eq("spur/rdata2", bus.rsp_rdata, 32'h5555_0002);
    check_eq("spur/busy2", 32'(bus.busy), 32'd0);

    // Reset while waiting on the master.
    @(negedge clk);
    bus.req_valid = 4'b0100;
    #1;
    check_eq("rstw/ready", 32'(bus.req_ready), 32'h4);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check_eq("rstw/start", 32'(bus.AXI_Start), 32'd1);
    @(negedge clk);
    #1;
    check_eq("rstw/busy_wait", 32'(bus.busy), 32'd1);
    rst           = 1'b1;
    bus.AXI_Done  = 1'b1;
    bus.AXI_RData = 32'h7777_7777;
    @(negedge clk);
    rst          = 1'b0;
    bus.AXI_Done = 1'b0;
    #1;
    check_eq("rstw/busy", 32'(bus.busy), 32'd0);
    check_eq("rstw/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rstw/start", 32'(bus.AXI_Start), 32'd0);
    check_eq("rstw/we", 32'(bus.AXI_WriteEn), 32'd0);
    check_eq("rstw/addr", bus.AXI_Addr, 32'd0);
    check_eq("rstw/wdata", bus.AXI_WData, 32'd0);
    check_eq("rstw/rdata", bus.rsp_rdata, 32'd0);
    @(negedge clk);
    #1;
    check_eq("rstw/rsp_valid2", 32'(bus.rsp_valid), 32'd0);
    check_eq("rstw/busy2", 32'(bus.busy), 32'd0);
    txn("post_rst", 4'b1111, 1'b0, 1, 32'h0BAD_F00D, 4'b0000, 4'b0001, 1'b0,
        addr_of[0], wdata_of[0]);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
